pwm_btn_conditioner: RTL and testbench

- Upstream input stage for the PWM duty-cycle controller.
- Takes two raw, asynchronous push-buttons (up/down) and synchronises them, debounces them and adds hold-to-auto-repeat.
- Produces single-cycle, mutually exclusive incr_duty / decr_duty pulses that drive the PWM block's duty-step inputs directly.
- Raw button bounce and both-buttons-held conflicts never reach the PWM stage.

---
 rtl/pwm_btn_conditioner.sv | 165 ++++++++++++++++
 tb/tb_pwm_btn_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_btn_conditioner.sv
// Button front end for the PWM duty controller: synchronise, debounce, and auto-repeat
// two raw buttons into mutually exclusive single-cycle duty step pulses.
`timescale 1ns/1ps
module pwm_btn_conditioner #(
  parameter int unsigned DBNC_CNT_MAX = 1000,
  parameter int unsigned RPT_DELAY    = 50_000_000,
  parameter int unsigned RPT_PERIOD   = 10_000_000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dn,
  output logic incr_duty,
  output logic decr_duty,
  output logic up_level,
  output logic dn_level,
  output logic locked
);

  localparam int unsigned DBNC_W  = $clog2(DBNC_CNT_MAX) + 1;
  localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [DBNC_W-1:0] DBNC_LAST   = DBNC_W'(DBNC_CNT_MAX - 1);
  localparam logic [RPT_W-1:0]  DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0]  PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);
  localparam logic              RPT_EN      = (RPT_DELAY != 0);

  typedef enum logic [2:0] {IDLE, HOLD_UP, RPT_UP, HOLD_DN, RPT_DN, LOCK} state_t;

  logic [SYNC_STAGES-1:0] sync_up, sync_dn;
  logic [1:0]             s_btn, lvl, lvl_d;
  logic [DBNC_W-1:0]      dbnc_cnt [2];
  logic [RPT_W-1:0]       rpt_cnt;
  logic                   rise_up, rise_dn;
  state_t                 state;

  // Multi-flop synchronisers; index 0 is the up channel, 1 the down channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_up <= '0;
      sync_dn <= '0;
    end else begin
      sync_up <= {sync_up[SYNC_STAGES-2:0], btn_up};
      sync_dn <= {sync_dn[SYNC_STAGES-2:0], btn_dn};
    end
  end

  assign s_btn = {sync_dn[SYNC_STAGES-1], sync_up[SYNC_STAGES-1]};

  // Level only follows the synchronised input after DBNC_CNT_MAX consecutive differing cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl   <= '0;
      lvl_d <= '0;
      for (int i = 0; i < 2; i++) dbnc_cnt[i] <= '0;
    end else begin
      lvl_d <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (s_btn[i] == lvl[i]) begin
          dbnc_cnt[i] <= '0;
        end else if (dbnc_cnt[i] == DBNC_LAST) begin
          lvl[i]      <= s_btn[i];
          dbnc_cnt[i] <= '0;
        end else begin
          dbnc_cnt[i] <= dbnc_cnt[i] + DBNC_W'(1);
        end
      end
    end
  end

  assign up_level = lvl[0];
  assign dn_level = lvl[1];
  assign rise_up  = lvl[0] & ~lvl_d[0];
  assign rise_dn  = lvl[1] & ~lvl_d[1];

  // Press/hold/repeat controller; a both-held conflict parks in LOCK until both are released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rpt_cnt   <= '0;
      incr_duty <= 1'b0;
      decr_duty <= 1'b0;
      locked    <= 1'b0;
    end else begin
      incr_duty <= 1'b0;
      decr_duty <= 1'b0;
      case (state)
        IDLE: begin
          rpt_cnt <= '0;
          if (lvl[0] && lvl[1]) begin
            state  <= LOCK;
            locked <= 1'b1;
          end else if (rise_up && !lvl[1]) begin
            state     <= HOLD_UP;
            incr_duty <= 1'b1;
          end else if (rise_dn && !lvl[0]) begin
            state     <= HOLD_DN;
            decr_duty <= 1'b1;
          end
        end
        HOLD_UP, RPT_UP: begin
          if (!lvl[0]) begin
            state   <= IDLE;
            rpt_cnt <= '0;
          end else if (lvl[1]) begin
            state   <= LOCK;
            locked  <= 1'b1;
            rpt_cnt <= '0;
          end else if (state == HOLD_UP) begin
            if (RPT_EN && rpt_cnt == DELAY_LAST) begin
              state     <= RPT_UP;
              incr_duty <= 1'b1;
              rpt_cnt   <= '0;
            end else if (RPT_EN) begin
              rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
          end else if (rpt_cnt == PERIOD_LAST) begin
            incr_duty <= 1'b1;
            rpt_cnt   <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
          end
        end
        HOLD_DN, RPT_DN: begin
          if (!lvl[1]) begin
            state   <= IDLE;
            rpt_cnt <= '0;
          end else if (lvl[0]) begin
            state   <= LOCK;
            locked  <= 1'b1;
            rpt_cnt <= '0;
          end else if (state == HOLD_DN) begin
            if (RPT_EN && rpt_cnt == DELAY_LAST) begin
              state     <= RPT_DN;
              decr_duty <= 1'b1;
              rpt_cnt   <= '0;
            end else if (RPT_EN) begin
              rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
          end else if (rpt_cnt == PERIOD_LAST) begin
            decr_duty <= 1'b1;
            rpt_cnt   <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
          end
        end
        LOCK: begin
          rpt_cnt <= '0;
          if (!lvl[0] && !lvl[1]) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rpt_cnt <= '0;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_btn_conditioner.sv
// Directed bench for pwm_btn_conditioner with short debounce/repeat parameters.
`timescale 1ns/1ps
module tb_pwm_btn_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic incr_duty, decr_duty, up_level, dn_level, locked;

  pwm_btn_conditioner #(
    .DBNC_CNT_MAX(4),
    .RPT_DELAY(20),
    .RPT_PERIOD(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_dn(btn_dn),
    .incr_duty(incr_duty),
    .decr_duty(decr_duty),
    .up_level(up_level),
    .dn_level(dn_level),
    .locked(locked)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int incr_t[$];
  int decr_cnt = 0;
  logic both_seen  = 1'b0;
  logic long_pulse = 1'b0;
  logic incr_prev  = 1'b0;
  logic decr_prev  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log taken mid-cycle: incr timestamps, decr count, overlap and width violations
  always @(negedge clk) begin
    if (incr_duty) incr_t.push_back(cyc);
    if (decr_duty) decr_cnt++;
    if (incr_duty && decr_duty) both_seen = 1'b1;
    if ((incr_duty && incr_prev) || (decr_duty && decr_prev)) long_pulse = 1'b1;
    incr_prev = incr_duty;
    decr_prev = decr_duty;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_run++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Posedges until incr_duty is seen high just after an edge; -1 when the budget expires
  task automatic wait_incr(input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      if (incr_duty) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k, tp, base, db, n1, dcnt, nat, guard;
    int offs[8];
    offs = '{0, 20, 28, 36, 44, 52, 60, 68};

    // Reset held with both buttons pressed
    btn_up = 1'b1;
    btn_dn = 1'b1;
    step(5);
    chk("rst_incr", int'(incr_duty), 0);
    chk("rst_decr", int'(decr_duty), 0);
    chk("rst_up_level", int'(up_level), 0);
    chk("rst_dn_level", int'(dn_level), 0);
    chk("rst_locked", int'(locked), 0);
    rst = 1'b1;
    step(15);
    chk("rst_rel_locked", int'(locked), 1);
    chk("rst_rel_up_level", int'(up_level), 1);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    step(15);
    chk("rst_unlock", int'(locked), 0);
    chk("rst_no_incr", incr_t.size(), 0);
    chk("rst_no_decr", decr_cnt, 0);

    // Bounce on btn_up, then steady press
    for (int i = 0; i < 16; i++) begin
      btn_up = (i % 2 == 0);
      step(2);
    end
    step(4);
    chk("bounce_no_pulse", incr_t.size(), 0);
    chk("bounce_level_low", int'(up_level), 0);
    base = incr_t.size();
    btn_up = 1'b1;
    wait_incr(20, k);
    tp = cyc;
    chk_rng("press_latency", k, 7, 9);
    chk("press_up_level", int'(up_level), 1);

    // Keep holding for the repeat train, release right after the 68-cycle repeat
    guard = 0;
    while (cyc < tp + 68 && guard < 100) begin
      step(1);
      guard++;
    end
    btn_up = 1'b0;
    step(30);
    chk("rpt_count", incr_t.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < incr_t.size()) chk($sformatf("rpt_offset_%0d", i), incr_t[base + i] - tp, offs[i]);
    end
    chk("rpt_released_level", int'(up_level), 0);

    // Short press on btn_dn
    db = decr_cnt;
    n1 = incr_t.size();
    btn_dn = 1'b1;
    step(10);
    btn_dn = 1'b0;
    step(5);
    chk("short_dn_level_held", int'(dn_level), 1);
    step(2);
    chk("short_dn_level_fell", int'(dn_level), 0);
    step(30);
    chk("short_one_decr", decr_cnt - db, 1);
    chk("short_no_incr", incr_t.size(), n1);

    // Conflict: up repeating, then dn pressed
    base = incr_t.size();
    btn_up = 1'b1;
    guard = 0;
    while (incr_t.size() < base + 2 && guard < 60) begin
      step(1);
      guard++;
    end
    chk("conf_repeating", int'(incr_t.size() >= base + 2), 1);
    btn_dn = 1'b1;
    step(10);
    chk("conf_locked", int'(locked), 1);
    n1 = incr_t.size();
    step(30);
    chk("conf_no_repeat", incr_t.size(), n1);
    dcnt = decr_cnt;
    btn_dn = 1'b0;
    step(20);
    chk("conf_dn_rel_locked", int'(locked), 1);
    chk("conf_dn_rel_level", int'(dn_level), 0);
    chk("conf_dn_rel_no_decr", decr_cnt, dcnt);
    chk("conf_dn_rel_no_incr", incr_t.size(), n1);
    btn_up = 1'b0;
    step(15);
    chk("conf_unlock", int'(locked), 0);
    chk("conf_up_rel_no_incr", incr_t.size(), n1);
    chk("conf_no_decr", decr_cnt, dcnt);

    // Asynchronous reset pulse while a repeat pulse is high
    base = incr_t.size();
    btn_up = 1'b1;
    guard = 0;
    while (incr_t.size() < base + 2 && guard < 60) begin
      step(1);
      guard++;
    end
    wait_incr(20, k);
    chk("arst_caught_pulse", int'(k > 0), 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_incr_drop", int'(incr_duty), 0);
    chk("arst_level_drop", int'(up_level), 0);
    chk("arst_locked", int'(locked), 0);
    #2 rst = 1'b1;
    nat = incr_t.size();
    wait_incr(20, k);
    chk_rng("arst_fresh_latency", k, 7, 9);
    #5;
    chk("arst_single_pulse", incr_t.size(), nat + 1);
    btn_up = 1'b0;
    step(15);

    chk("never_both", int'(both_seen), 0);
    chk("pulse_width_one", int'(long_pulse), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
